wam_ctl: RTL

Game sequencer for whack-a-mole. Spawns one mole at a time into a pseudo-random hole and times its visibility by difficulty. Detects hits from the tap vector, keeps the BCD score, and runs the round timer. It drives the holes[7:0] and score[11:0] inputs of the board top level (LED and digit display path) and consumes the debounced tap vector and difficulty level from that top level.

---
 rtl/wam_ctl_if.sv | 35 +++
 rtl/wam_ctl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wam_ctl_if.sv
// ---------------------------------------------------------------------------
// wam_ctl_if
// Signal bundle between the whack-a-mole sequencer and the board top level.
//   master : board side   - drives tick/start/tap/hrdn, reads game outputs
//   slave  : wam_ctl side - reads controls, drives holes/score/time/game_over
// Signals:
//   tick      1  one-clk game-time enable (~100 Hz)
//   start     1  one-clk pulse, starts or restarts a round
//   tap       8  level tap switches, one per hole (debounced, clk-synchronous)
//   hrdn      2  difficulty level
//   holes     8  one-hot active mole, or 0
//   score    12  three-digit BCD score
//   time_left 13 ticks remaining in the round
//   game_over 1  high once the round has ended
// ---------------------------------------------------------------------------
interface wam_ctl_if;
  logic        tick;
  logic        start;
  logic [7:0]  tap;
  logic [1:0]  hrdn;
  logic [7:0]  holes;
  logic [11:0] score;
  logic [12:0] time_left;
  logic        game_over;

  modport master (
    output tick, start, tap, hrdn,
    input  holes, score, time_left, game_over
  );

  modport slave (
    input  tick, start, tap, hrdn,
    output holes, score, time_left, game_over
  );
endinterface

// File: rtl/wam_ctl.sv
// ---------------------------------------------------------------------------
// wam_ctl - whack-a-mole game sequencer
// Spawns one mole at a time into a pseudo-random hole, times its visibility
// by difficulty, detects hits on the tap vector, keeps a saturating BCD score
// and runs the round timer.
// Ports:
//   clk  - system clock
//   clr  - asynchronous reset, active-high
//   bus  - wam_ctl_if.slave (tick, start, tap, hrdn in; holes, score,
//          time_left, game_over out; all outputs registered)
// Build option:
//   MISS_PENALTY_EN - when defined, a tap edge on a non-active hole while a
//   mole is up (and no valid hit in the same clk) takes one point off the
//   score, floored at 000.
// ---------------------------------------------------------------------------
module wam_ctl #(
  parameter int GAME_TICKS = 6000,
  parameter int GAP_TICKS  = 20,
  parameter int LIFE_EASY  = 150,
  parameter int LIFE_MED   = 100,
  parameter int LIFE_HARD  = 60
) (
  input  logic     clk,
  input  logic     clr,
  wam_ctl_if.slave bus
);

  localparam int CNT_W = 16;
  localparam logic [12:0]      GAME_INIT = 13'(GAME_TICKS);
  localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_TICKS);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;

  state_t           state_reg, state_next;
  logic [15:0]      lfsr_reg;
  logic [15:0]      lfsr_next;
  logic [7:0]       tap_q_reg;
  logic [7:0]       hit_vec_reg;
  logic [7:0]       holes_reg, holes_next;
  logic [11:0]      score_reg, score_next;
  logic [12:0]      time_reg, time_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       prev_reg, prev_next;
  logic             over_reg, over_next;

  logic             hit;
  logic             final_tick;
  logic             cnt_last;
  logic [2:0]       spawn_idx;
  logic [CNT_W-1:0] life_sel;
`ifdef MISS_PENALTY_EN
  logic             miss;
`endif

  // Saturating three-digit BCD increment (999 holds).
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, o;
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    if (v == 12'h999) return v;
    if (o != 4'd9) begin
      o = o + 4'd1;
    end else begin
      o = 4'd0;
      if (t != 4'd9) begin
        t = t + 4'd1;
      end else begin
        t = 4'd0;
        h = h + 4'd1;
      end
    end
    return {h, t, o};
  endfunction

`ifdef MISS_PENALTY_EN
  // BCD decrement with a floor at 000.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, o;
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    if (v == 12'h000) return v;
    if (o != 4'd0) begin
      o = o - 4'd1;
    end else begin
      o = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, o};
  endfunction
`endif

  // Fibonacci LFSR x^16+x^14+x^13+x^11, shifting right; the seed is non-zero
  // and the polynomial is maximal, so the register never reaches zero.
  assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                      lfsr_reg[15:1]};

  // The edge vector is registered, so a tap reaches the FSM one clk after
  // tap_q sees it; hits are qualified against the mole currently shown.
  assign hit        = |(hit_vec_reg & holes_reg);
`ifdef MISS_PENALTY_EN
  assign miss       = |(hit_vec_reg & ~holes_reg);
`endif
  assign final_tick = bus.tick && (time_reg == 13'd1);
  assign cnt_last   = (cnt_reg <= CNT_W'(1));

  // Never land on the same hole twice in a row.
  assign spawn_idx  = (lfsr_reg[2:0] == prev_reg) ? lfsr_reg[2:0] + 3'd1
                                                  : lfsr_reg[2:0];

  always_comb begin
    life_sel = CNT_W'(LIFE_HARD);
    case (bus.hrdn)
      2'd0:    life_sel = CNT_W'(LIFE_EASY);
      2'd1:    life_sel = CNT_W'(LIFE_MED);
      default: life_sel = CNT_W'(LIFE_HARD);
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= IDLE;
      lfsr_reg    <= LFSR_SEED;
      tap_q_reg   <= '0;
      hit_vec_reg <= '0;
      holes_reg   <= '0;
      score_reg   <= '0;
      time_reg    <= GAME_INIT;
      cnt_reg     <= GAP_INIT;
      prev_reg    <= '0;
      over_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      tap_q_reg   <= bus.tap;
      hit_vec_reg <= bus.tap & ~tap_q_reg;
      holes_reg   <= holes_next;
      score_reg   <= score_next;
      time_reg    <= time_next;
      cnt_reg     <= cnt_next;
      prev_reg    <= prev_next;
      over_reg    <= over_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    holes_next = holes_reg;
    score_next = score_reg;
    time_next  = time_reg;
    cnt_next   = cnt_reg;
    prev_next  = prev_reg;
    over_next  = over_reg;

    if (bus.start) begin
      // start restarts from any state, including mid-round.
      state_next = GAP;
      holes_next = '0;
      score_next = '0;
      time_next  = GAME_INIT;
      cnt_next   = GAP_INIT;
      over_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          holes_next = '0;
        end

        GAP: begin
          holes_next = '0;
          if (bus.tick) begin
            time_next = time_reg - 13'd1;
            cnt_next  = cnt_reg - CNT_W'(1);
            if (cnt_last) begin
              // hrdn is only looked at here; later changes do not affect
              // the mole already on the board.
              state_next = SHOW;
              holes_next = 8'd1 << spawn_idx;
              prev_next  = spawn_idx;
              cnt_next   = life_sel;
            end
          end
        end

        SHOW: begin
          if (bus.tick) time_next = time_reg - 13'd1;
`ifdef MISS_PENALTY_EN
          if (miss && !hit) score_next = bcd_dec(score_reg);
`endif
          if (hit) begin
            // A hit wins over an expiry in the same clk.
            score_next = bcd_inc(score_reg);
            holes_next = '0;
            cnt_next   = GAP_INIT;
            state_next = GAP;
          end else if (bus.tick && cnt_last) begin
            holes_next = '0;
            cnt_next   = GAP_INIT;
            state_next = GAP;
          end else if (bus.tick) begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end

        OVER: begin
          holes_next = '0;
          time_next  = '0;
          over_next  = 1'b1;
        end

        default: begin
          state_next = IDLE;
        end
      endcase

      // Round end overrides the mole bookkeeping but keeps any score
      // change made in the same clk.
      if ((state_reg == GAP || state_reg == SHOW) && final_tick) begin
        state_next = OVER;
        holes_next = '0;
        time_next  = '0;
        over_next  = 1'b1;
      end
    end
  end

  assign bus.holes     = holes_reg;
  assign bus.score     = score_reg;
  assign bus.time_left = time_reg;
  assign bus.game_over = over_reg;

endmodule
